// File: rtl/shift_tx8_pkg.sv
// Shared definitions for the shift_tx8 serial byte transmitter.
package shift_tx8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/shift_tx8_bit_timer.sv
// Bit-period timer: ticks on the last cycle of each serial bit, held at zero while disabled.
module shift_tx8_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_tx8.sv
// Byte transmitter: one-entry holding register feeding a start/8-data/stop serialiser.
module shift_tx8 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  import shift_tx8_pkg::*;

  state_t     state;
  logic [7:0] hold;
  logic [7:0] shift;
  logic       hold_full;
  logic [2:0] bit_idx;
  logic       tick;

  assign in_ready = ~hold_full;

  shift_tx8_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state != IDLE),
    .tick   (tick)
  );

  // Holding register data carries no reset; hold_full qualifies it.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      hold <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx        <= LINE_IDLE;
      busy      <= 1'b0;
      hold_full <= 1'b0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      if (in_valid && in_ready) begin
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            shift     <= hold;
            hold_full <= 1'b0;
            state     <= START;
            tx        <= LINE_START;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= LINE_IDLE;
            end else begin
              tx <= shift[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            // A queued byte starts straight away so back-to-back frames have no gap.
            if (hold_full) begin
              shift     <= hold;
              hold_full <= 1'b0;
              state     <= START;
              tx        <= LINE_START;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx8.sv
// Directed bench for shift_tx8 at CLKS_PER_BIT=4 (dut) and CLKS_PER_BIT=1 (dut1).
module tb_shift_tx8;

  import shift_tx8_pkg::*;

  localparam int CPB = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [7:0] in_data1 = '0;
  logic       in_valid1 = 1'b0;
  logic       in_ready1, tx1, busy1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_tx8 #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  shift_tx8 #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i == FRAME_BITS - 1) return 1'b1;
    return d[i-1];
  endfunction

  // Caller must be positioned #1 after the edge that starts frame cycle 'first'.
  task automatic expect_frame(input logic [7:0] d, input int first, input string tag);
    for (int k = first; k < FRAME_CYC; k++) begin
      chk($sformatf("%s_tx%0d", tag, k), tx, fbit(d, k / CPB));
      chk($sformatf("%s_busy%0d", tag, k), busy, 1);
      step();
    end
  endtask

  task automatic wait_fall(input string tag);
    for (int i = 0; i < 20 && tx; i++) step();
    chk({tag, "_fall"}, tx, 0);
  endtask

  initial begin
    int lows, errs_tx, errs_busy, errs_rdy, stall;
    logic acc;
    logic [7:0] bytes [3];

    // Reset state
    step(); step();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_tx1", tx1, 1);
    reset_n = 1'b1;
    step();

    // Single byte 0xA5
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("a5_ready_low", in_ready, 0);
    chk("a5_tx_not_yet", tx, 1);
    chk("a5_busy_not_yet", busy, 0);
    step();
    expect_frame(8'hA5, 0, "a5");
    chk("a5_busy_end", busy, 0);
    chk("a5_tx_end", tx, 1);
    chk("a5_ready_end", in_ready, 1);
    step(); step();

    // Back-to-back 0x00 then 0xFF
    in_data = 8'h00; in_valid = 1'b1;
    step();
    chk("b2b_ready_drop", in_ready, 0);
    in_data = 8'hFF;
    step();
    chk("b2b_ready_back", in_ready, 1);
    chk("b2b_tx0", tx, 0);
    step();
    in_valid = 1'b0;
    chk("b2b_ready_q", in_ready, 0);
    expect_frame(8'h00, 1, "b2b0");
    expect_frame(8'hFF, 0, "b2b1");
    chk("b2b_busy_end", busy, 0);
    step(); step();

    // Backpressure: 0x11, 0x22, 0x33 with in_valid held
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          in_data = bytes[b]; in_valid = 1'b1;
          stall = 0;
          for (int c = 0; c < 200; c++) begin
            acc = in_ready;
            step();
            stall++;
            if (acc) break;
          end
          if (b == 2) chk("bp_stall33", stall, 40);
          if (b == 1) chk("bp_stall22", stall, 2);
        end
        in_valid = 1'b0;
      end
      begin
        wait_fall("bp");
        expect_frame(8'h11, 0, "bp11");
        expect_frame(8'h22, 0, "bp22");
        expect_frame(8'h33, 0, "bp33");
        chk("bp_busy_end", busy, 0);
      end
    join
    step(); step();

    // Reset mid-frame during data bit 3, with a second byte queued
    in_data = 8'hC3; in_valid = 1'b1;
    step();
    in_data = 8'h3C;
    step();
    step();
    in_valid = 1'b0;
    chk("mr_queued", in_ready, 0);
    for (int i = 0; i < 16; i++) step();
    chk("mr_bit3", tx, fbit(8'hC3, 4));
    reset_n = 1'b0;
    step();
    chk("mr_tx", tx, 1);
    chk("mr_busy", busy, 0);
    chk("mr_ready", in_ready, 1);
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
      step();
    end
    chk("mr_no_residual", lows, 0);
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    expect_frame(8'h5A, 0, "mr5a");
    chk("mr_busy_end", busy, 0);

    // CLKS_PER_BIT=1, 0x80
    in_data1 = 8'h80; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("c1_tx_not_yet", tx1, 1);
    step();
    for (int k = 0; k < FRAME_BITS; k++) begin
      chk($sformatf("c1_tx%0d", k), tx1, fbit(8'h80, k));
      chk($sformatf("c1_busy%0d", k), busy1, 1);
      step();
    end
    chk("c1_busy_end", busy1, 0);
    chk("c1_tx_end", tx1, 1);

    // Idle hygiene
    errs_tx = 0; errs_busy = 0; errs_rdy = 0;
    for (int i = 0; i < 100; i++) begin
      in_data = 8'($urandom);
      in_data1 = 8'($urandom);
      step();
      if (tx !== 1'b1 || tx1 !== 1'b1) errs_tx++;
      if (busy !== 1'b0 || busy1 !== 1'b0) errs_busy++;
      if (in_ready !== 1'b1 || in_ready1 !== 1'b1) errs_rdy++;
    end
    chk("idle_tx", errs_tx, 0);
    chk("idle_busy", errs_busy, 0);
    chk("idle_ready", errs_rdy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
